parking_counter: RTL and testbench
==================================

PARKING_COUNTER -- requirements
Module: parking_counter

Interface
REQ-001 SHALL have parameter CAPACITY, default 20, maximum lot occupancy (legal range 1..99).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 100000, number of stable cycles required to accept a sensor level (1 ms at 100 MHz).
REQ-003 SHALL have port clock  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sensor_a  input  1  raw outer beam sensor, 1 = beam broken, asynchronous to clock.
REQ-006 SHALL have port sensor_b  input  1  raw inner beam sensor, 1 = beam broken, asynchronous to clock.
REQ-007 SHALL have port digit1  output  4  ones digit of occupancy, BCD 0..9; drives the display driver's digit1.
REQ-008 SHALL have port digit2  output  4  tens digit of occupancy, BCD 0..9; drives the display driver's digit2.
REQ-009 SHALL have port lot_full  output  1  high while occupancy == CAPACITY.
REQ-010 SHALL have port lot_empty  output  1  high while occupancy == 0.
REQ-011 SHALL have port car_in  output  1  one-cycle pulse when a completed entry is counted.
REQ-012 SHALL have port car_out  output  1  one-cycle pulse when a completed exit is counted.
REQ-013 SHALL have port reject  output  1  one-cycle pulse when a completed entry at full, or a completed exit at empty, is not counted.

Function
REQ-014 Each raw sensor SHALL pass a 2-flop synchronizer, then a debouncer.
REQ-015 Debounced level SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 Any bounce SHALL restart the debounce count.
REQ-017 The gate FSM SHALL have states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A and SHALL be driven by debounced {a,b}.
REQ-018 IDLE: 10 -> IN_A; 01 -> OUT_B; 00 and 11 -> stay IDLE.
REQ-019 Entry path: IN_A 11 -> IN_AB, 00 -> IDLE; IN_AB 01 -> IN_B, 10 -> IN_A; IN_B 00 -> IDLE with entry completion, 11 -> IN_AB, 10 -> IDLE without count.
REQ-020 Exit path SHALL mirror the entry path: OUT_B, OUT_AB, OUT_A; OUT_A 00 -> IDLE with exit completion.
REQ-021 Any input combination not listed in REQ-018..REQ-020 SHALL hold the current state.
REQ-022 Occupancy SHALL be held as two BCD digit registers, never binary, and SHALL always satisfy 0 <= value <= CAPACITY.
REQ-023 Entry completion with occupancy < CAPACITY SHALL increment with BCD carry (09 -> 10) and pulse car_in.
REQ-024 Exit completion with occupancy > 0 SHALL decrement with BCD borrow (10 -> 09) and pulse car_out.
REQ-025 Entry completion at full, or exit completion at empty, SHALL leave the count unchanged and pulse reject.
REQ-026 The digit, flag and pulse updates SHALL be registered and visible in the cycle after the FSM leaves IN_B / OUT_A (one-cycle latency).
REQ-027 lot_full and lot_empty SHALL be registered and consistent with the digits in the same cycle.
REQ-028 car_in, car_out and reject SHALL each be one-hot per completion and never asserted together.

Reset
REQ-029 While reset == 0 at a rising edge: FSM -> IDLE; digits -> 0; lot_empty = 1; lot_full = 0; car_in, car_out, reject = 0.
REQ-030 While reset == 0 at a rising edge, the debounced levels and debounce counters SHALL clear to 0.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence without counting.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the CAPACITY and DEBOUNCE_CYCLES defaults, and the BCD increment/decrement helpers.
REQ-033 Synchronizer plus debouncer SHALL be a sub-module sensor_debounce, instantiated once per sensor.

Verification (DEBOUNCE_CYCLES=4, CAPACITY=12)
REQ-034 Clean entry: a/b = 10,11,01,00, each held 10 cycles -> one car_in pulse; digit2:digit1 goes 0:0 -> 0:1; lot_empty falls.
REQ-035 BCD carry/borrow: from 0:9 one entry -> 1:0; one exit -> 0:9; a bench with CAPACITY=10 sees lot_full rise at 1:0.
REQ-036 Full/empty: 12 entries then 1 more -> count 1:2, reject pulse, no car_in; from 0:0 one exit -> reject pulse, count 0:0.
REQ-037 Abort and bounce: entry 10,11,10,00 -> no count change; a 3-cycle glitch on sensor_a -> FSM stays IDLE.
REQ-038 Reset asserted while in IN_AB -> next cycle IDLE, 0:0, lot_empty=1; the following clean entry counts normally.

Source files
------------

// File: rtl/parking_counter_pkg.sv
// Shared definitions for the parking lot counter: gate FSM encoding,
// parameter defaults and two-digit BCD arithmetic helpers.
package parking_counter_pkg;

  localparam int DEFAULT_CAPACITY        = 20;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  // Gate sequence states; IN_* track an entering car, OUT_* an exiting one.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IN_A   = 3'd1,
    ST_IN_AB  = 3'd2,
    ST_IN_B   = 3'd3,
    ST_OUT_B  = 3'd4,
    ST_OUT_AB = 3'd5,
    ST_OUT_A  = 3'd6
  } gate_state_t;

  // Occupancy as two BCD digits, tens in the upper nibble.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Add one with carry from ones into tens (09 -> 10).
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  // Subtract one with borrow from tens into ones (10 -> 09).
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = v.tens - 4'd1;
    end else begin
      r.ones = v.ones - 4'd1;
    end
    return r;
  endfunction

  // Convert an elaboration-time integer (0..99) to two BCD digits.
  function automatic bcd2_t to_bcd(input int n);
    bcd2_t r;
    r.tens = 4'(n / 10);
    r.ones = 4'(n % 10);
    return r;
  endfunction

endpackage

// File: rtl/parking_counter_sensor_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one beam sensor.
// The debounced level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous beam signal into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q2 == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      level <= sync_q2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_counter.sv
// Parking lot occupancy counter. Two beam sensors (a = outer, b = inner)
// are debounced and fed to a gate FSM that recognises complete entry and
// exit sequences; completions update a saturating two-digit BCD count.
// state_dbg exposes the gate FSM state for observation.
module parking_counter
  import parking_counter_pkg::*;
#(
  parameter int CAPACITY        = DEFAULT_CAPACITY,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_a,
  input  logic        sensor_b,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic        lot_full,
  output logic        lot_empty,
  output logic        car_in,
  output logic        car_out,
  output logic        reject,
  output gate_state_t state_dbg
);

  localparam bcd2_t CAP_BCD = to_bcd(CAPACITY);

  logic        a_db;
  logic        b_db;
  logic [1:0]  ab;
  gate_state_t state;
  gate_state_t state_nxt;
  logic        entry_done;
  logic        exit_done;
  bcd2_t       count;
  bcd2_t       count_nxt;
  logic        in_nxt;
  logic        out_nxt;
  logic        rej_nxt;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clock (clock),
    .reset (reset),
    .raw   (sensor_a),
    .level (a_db)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clock (clock),
    .reset (reset),
    .raw   (sensor_b),
    .level (b_db)
  );

  assign ab = {a_db, b_db};

  // Gate FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Gate FSM transitions; unlisted input combinations hold the state.
  always_comb begin
    state_nxt  = state;
    entry_done = 1'b0;
    exit_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ab == 2'b10)      state_nxt = ST_IN_A;
        else if (ab == 2'b01) state_nxt = ST_OUT_B;
      end
      ST_IN_A: begin
        if (ab == 2'b11)      state_nxt = ST_IN_AB;
        else if (ab == 2'b00) state_nxt = ST_IDLE;
      end
      ST_IN_AB: begin
        if (ab == 2'b01)      state_nxt = ST_IN_B;
        else if (ab == 2'b10) state_nxt = ST_IN_A;
      end
      ST_IN_B: begin
        if (ab == 2'b00) begin
          state_nxt  = ST_IDLE;
          entry_done = 1'b1;
        end else if (ab == 2'b11) begin
          state_nxt = ST_IN_AB;
        end else if (ab == 2'b10) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OUT_B: begin
        if (ab == 2'b11)      state_nxt = ST_OUT_AB;
        else if (ab == 2'b00) state_nxt = ST_IDLE;
      end
      ST_OUT_AB: begin
        if (ab == 2'b10)      state_nxt = ST_OUT_A;
        else if (ab == 2'b01) state_nxt = ST_OUT_B;
      end
      ST_OUT_A: begin
        if (ab == 2'b00) begin
          state_nxt = ST_IDLE;
          exit_done = 1'b1;
        end else if (ab == 2'b11) begin
          state_nxt = ST_OUT_AB;
        end else if (ab == 2'b01) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decide the count update and which single pulse a completion produces.
  always_comb begin
    count_nxt = count;
    in_nxt    = 1'b0;
    out_nxt   = 1'b0;
    rej_nxt   = 1'b0;
    if (entry_done) begin
      if (count != CAP_BCD) begin
        count_nxt = bcd_inc(count);
        in_nxt    = 1'b1;
      end else begin
        rej_nxt = 1'b1;
      end
    end else if (exit_done) begin
      if (count != '0) begin
        count_nxt = bcd_dec(count);
        out_nxt   = 1'b1;
      end else begin
        rej_nxt = 1'b1;
      end
    end
  end

  // Register count, flags and pulses together so flags always match digits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      lot_full  <= 1'b0;
      lot_empty <= 1'b1;
      car_in    <= 1'b0;
      car_out   <= 1'b0;
      reject    <= 1'b0;
    end else begin
      count     <= count_nxt;
      lot_full  <= (count_nxt == CAP_BCD);
      lot_empty <= (count_nxt == '0);
      car_in    <= in_nxt;
      car_out   <= out_nxt;
      reject    <= rej_nxt;
    end
  end

  assign digit1    = count.ones;
  assign digit2    = count.tens;
  assign state_dbg = state;

endmodule

// File: tb/tb_parking_counter.sv
// Bench for parking_counter: a CAPACITY=12 unit under full checking and a
// CAPACITY=10 unit sharing the same sensor stimulus for the carry/full case.
module tb_parking_counter;
  import parking_counter_pkg::*;

  localparam int CAP   = 12;
  localparam int CAP_T = 10;
  localparam int DB    = 4;
  localparam int HOLD  = 10;

  // Sensor sequences, first step in the low bits: {s4,s3,s2,s1,s0}.
  localparam logic [9:0] SEQ_ENTRY     = {2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [9:0] SEQ_EXIT      = {2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
  localparam logic [9:0] SEQ_ABORT_IN  = {2'b00, 2'b00, 2'b10, 2'b11, 2'b10};
  localparam logic [9:0] SEQ_ABORT_OUT = {2'b00, 2'b00, 2'b01, 2'b11, 2'b01};
  localparam logic [9:0] SEQ_BACKOUT   = {2'b00, 2'b10, 2'b01, 2'b11, 2'b10};

  localparam int G_ENTRY     = 0;
  localparam int G_EXIT      = 1;
  localparam int G_ABORT_IN  = 2;
  localparam int G_ABORT_OUT = 3;
  localparam int G_BACKOUT   = 4;
  localparam int G_GLITCH    = 5;

  logic        clock;
  logic        reset;
  logic        sensor_a;
  logic        sensor_b;
  logic [3:0]  digit1, digit2;
  logic        lot_full, lot_empty, car_in, car_out, reject;
  gate_state_t state_dbg;
  logic [3:0]  t_digit1, t_digit2;
  logic        t_full, t_empty, t_in, t_out, t_rej;
  gate_state_t t_state;

  int tests = 0;
  int fails = 0;
  int in_cnt = 0, out_cnt = 0, rej_cnt = 0, multi_cnt = 0;
  int exp_in = 0, exp_out = 0, exp_rej = 0;
  int occ = 0, occ_t = 0;
  int b_in, b_out, b_rej;

  typedef struct {
    logic [9:0] seq;
    int         n;
    int         d2;
    int         d1;
    int         din;
    int         dout;
    int         drej;
    logic       empty;
    logic       full;
  } vec_t;
  vec_t vecs[9];

  parking_counter #(.CAPACITY(CAP), .DEBOUNCE_CYCLES(DB)) u_dut (
    .clock(clock), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .digit1(digit1), .digit2(digit2), .lot_full(lot_full), .lot_empty(lot_empty),
    .car_in(car_in), .car_out(car_out), .reject(reject), .state_dbg(state_dbg)
  );

  parking_counter #(.CAPACITY(CAP_T), .DEBOUNCE_CYCLES(DB)) u_dut10 (
    .clock(clock), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .digit1(t_digit1), .digit2(t_digit2), .lot_full(t_full), .lot_empty(t_empty),
    .car_in(t_in), .car_out(t_out), .reject(t_rej), .state_dbg(t_state)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pulse monitor: counts every high cycle, so a stretched pulse shows up.
  always @(negedge clock) begin
    if (reset) begin
      if (car_in)  in_cnt++;
      if (car_out) out_cnt++;
      if (reject)  rej_cnt++;
      if ((int'(car_in) + int'(car_out) + int'(reject)) > 1) multi_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_seq(input logic [9:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      {sensor_a, sensor_b} = seq[2*i +: 2];
      repeat (HOLD) @(negedge clock);
    end
  endtask

  // Compare both units against the occupancy model and pulse expectations.
  task automatic check_state(input string tag);
    check({tag, " digit2"}, int'(digit2), occ / 10);
    check({tag, " digit1"}, int'(digit1), occ % 10);
    check({tag, " lot_full"}, int'(lot_full), int'(occ == CAP));
    check({tag, " lot_empty"}, int'(lot_empty), int'(occ == 0));
    check({tag, " car_in count"}, in_cnt, exp_in);
    check({tag, " car_out count"}, out_cnt, exp_out);
    check({tag, " reject count"}, rej_cnt, exp_rej);
    check({tag, " cap10 count"}, int'(t_digit2) * 10 + int'(t_digit1), occ_t);
    check({tag, " cap10 full"}, int'(t_full), int'(occ_t == CAP_T));
  endtask

  // Apply one gesture and update the occupancy model from the lot rules.
  task automatic gesture(input int kind);
    int len;
    case (kind)
      G_ENTRY: begin
        do_seq(SEQ_ENTRY, 4);
        if (occ < CAP) begin occ++; exp_in++; end
        else exp_rej++;
        if (occ_t < CAP_T) occ_t++;
      end
      G_EXIT: begin
        do_seq(SEQ_EXIT, 4);
        if (occ > 0) begin occ--; exp_out++; end
        else exp_rej++;
        if (occ_t > 0) occ_t--;
      end
      G_ABORT_IN:  do_seq(SEQ_ABORT_IN, 4);
      G_ABORT_OUT: do_seq(SEQ_ABORT_OUT, 4);
      G_BACKOUT:   do_seq(SEQ_BACKOUT, 5);
      default: begin
        len = $urandom_range(1, DB - 1);
        if ($urandom_range(0, 1) == 1) sensor_a = 1'b1;
        else sensor_b = 1'b1;
        repeat (len) @(negedge clock);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (HOLD) @(negedge clock);
      end
    endcase
    check_state($sformatf("gesture%0d", kind));
  endtask

  initial begin
    int idle_miss;
    reset    = 1'b0;
    sensor_a = 1'b0;
    sensor_b = 1'b0;

    vecs[0] = '{SEQ_EXIT,      4, 0, 0, 0, 0, 1, 1'b1, 1'b0};
    vecs[1] = '{SEQ_ENTRY,     4, 0, 1, 1, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{SEQ_ABORT_IN,  4, 0, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[3] = '{SEQ_ENTRY,     4, 0, 2, 1, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{SEQ_EXIT,      4, 0, 1, 0, 1, 0, 1'b0, 1'b0};
    vecs[5] = '{SEQ_BACKOUT,   5, 0, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[6] = '{SEQ_ABORT_OUT, 4, 0, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[7] = '{SEQ_EXIT,      4, 0, 0, 0, 1, 0, 1'b1, 1'b0};
    vecs[8] = '{SEQ_ENTRY,     4, 0, 1, 1, 0, 0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset digit2", int'(digit2), 0);
    check("reset digit1", int'(digit1), 0);
    check("reset lot_empty", int'(lot_empty), 1);
    check("reset lot_full", int'(lot_full), 0);
    check("reset pulses", int'(car_in) + int'(car_out) + int'(reject), 0);
    check("reset state", int'(state_dbg == ST_IDLE), 1);
    reset = 1'b1;
    repeat (HOLD) @(negedge clock);

    // Table-driven gestures from an empty lot
    for (int i = 0; i < 9; i++) begin
      b_in  = in_cnt;
      b_out = out_cnt;
      b_rej = rej_cnt;
      do_seq(vecs[i].seq, vecs[i].n);
      check($sformatf("vec%0d digit2", i), int'(digit2), vecs[i].d2);
      check($sformatf("vec%0d digit1", i), int'(digit1), vecs[i].d1);
      check($sformatf("vec%0d car_in", i), in_cnt - b_in, vecs[i].din);
      check($sformatf("vec%0d car_out", i), out_cnt - b_out, vecs[i].dout);
      check($sformatf("vec%0d reject", i), rej_cnt - b_rej, vecs[i].drej);
      check($sformatf("vec%0d lot_empty", i), int'(lot_empty), int'(vecs[i].empty));
      check($sformatf("vec%0d lot_full", i), int'(lot_full), int'(vecs[i].full));
      exp_in  += vecs[i].din;
      exp_out += vecs[i].dout;
      exp_rej += vecs[i].drej;
    end
    occ   = 1;
    occ_t = 1;

    // BCD carry and borrow around 09/10; CAPACITY=10 unit goes full at 10
    while (occ < 9) gesture(G_ENTRY);
    gesture(G_ENTRY);
    check("carry digit2", int'(digit2), 1);
    check("carry digit1", int'(digit1), 0);
    check("cap10 full at 10", int'(t_full), 1);
    gesture(G_EXIT);
    check("borrow digits", int'({digit2, digit1}), 9);
    check("cap10 full cleared", int'(t_full), 0);

    // Fill to capacity, then one more entry is rejected
    while (occ < CAP) gesture(G_ENTRY);
    check("full flag at 12", int'(lot_full), 1);
    b_in  = in_cnt;
    b_rej = rej_cnt;
    gesture(G_ENTRY);
    check("reject at full", rej_cnt - b_rej, 1);
    check("no car_in at full", in_cnt - b_in, 0);
    check("count held at 12", int'({digit2, digit1}), 8'h12);

    // Random gestures against the occupancy model
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 7);
      if (r <= 1)      gesture(G_ENTRY);
      else if (r <= 3) gesture(G_EXIT);
      else if (r == 4) gesture(G_ABORT_IN);
      else if (r == 5) gesture(G_ABORT_OUT);
      else if (r == 6) gesture(G_BACKOUT);
      else             gesture(G_GLITCH);
    end

    // Three-cycle glitch on sensor_a must not move the FSM
    idle_miss = 0;
    sensor_a = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (state_dbg != ST_IDLE) idle_miss++;
    end
    sensor_a = 1'b0;
    repeat (HOLD) begin
      @(negedge clock);
      if (state_dbg != ST_IDLE) idle_miss++;
    end
    check("glitch non-idle cycles", idle_miss, 0);
    check_state("after glitch");

    // Reset while in IN_AB abandons the entry
    sensor_a = 1'b1; sensor_b = 1'b0;
    repeat (HOLD) @(negedge clock);
    sensor_b = 1'b1;
    repeat (HOLD) @(negedge clock);
    check("reached IN_AB", int'(state_dbg == ST_IN_AB), 1);
    reset = 1'b0;
    @(negedge clock);
    check("mid reset state", int'(state_dbg == ST_IDLE), 1);
    check("mid reset count", int'({digit2, digit1}), 0);
    check("mid reset lot_empty", int'(lot_empty), 1);
    reset = 1'b1;
    occ   = 0;
    occ_t = 0;
    sensor_a = 1'b0; sensor_b = 1'b0;
    repeat (HOLD) @(negedge clock);
    check_state("after mid reset");
    gesture(G_ENTRY);
    check("entry after reset", int'({digit2, digit1}), 8'h01);

    check("simultaneous pulses", multi_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
